// File: rtl/e_mdu.sv
// e_mdu: Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue, parked in pending registers and committed after a fixed busy period.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2(DIV_CYCLES) + 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   hi_pend;
    logic [31:0]   lo_pend;

    logic          is_mul;
    logic          is_div;
    logic          div_signed;
    logic          div_zero;
    logic [63:0]   product;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    logic [31:0]   mag_q;
    logic [31:0]   mag_r;
    logic [31:0]   calc_hi;
    logic [31:0]   calc_lo;
    logic [CW-1:0] load_cnt;

    // Signed division works on magnitudes; quotient sign is the XOR of operand signs,
    // remainder sign follows the dividend. A zero divisor keeps the current HI/LO.
    always_comb begin
        is_mul     = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
        is_div     = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
        div_signed = (mdu_op == OP_DIV);
        div_zero   = (rt_val == 32'd0);

        if (mdu_op == OP_MULT) begin
            product = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        end else begin
            product = {32'd0, rs_val} * {32'd0, rt_val};
        end

        mag_a = (div_signed && rs_val[31]) ? -rs_val : rs_val;
        mag_b = (div_signed && rt_val[31]) ? -rt_val : rt_val;
        mag_q = '0;
        mag_r = '0;
        if (!div_zero) begin
            mag_q = mag_a / mag_b;
            mag_r = mag_a % mag_b;
        end

        if (is_mul) begin
            calc_hi = product[63:32];
            calc_lo = product[31:0];
        end else if (div_zero) begin
            calc_hi = hi;
            calc_lo = lo;
        end else begin
            calc_lo = (div_signed && (rs_val[31] ^ rt_val[31])) ? -mag_q : mag_q;
            calc_hi = (div_signed && rs_val[31]) ? -mag_r : mag_r;
        end

        load_cnt = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end

    // Starts arriving while RUN are dropped; commit happens on the edge that sees cnt == 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            hi_pend <= '0;
            lo_pend <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul || is_div) begin
                            hi_pend <= calc_hi;
                            lo_pend <= calc_lo;
                            cnt     <= load_cnt;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end else if (mdu_op == OP_MTHI) begin
                            hi <= rs_val;
                        end else if (mdu_op == OP_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        hi    <= hi_pend;
                        lo    <= lo_pend;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed and randomized checks of e_mdu against an arithmetic HI/LO model.
module tb_e_mdu;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] modelHi    = '0;
    logic [31:0] modelLo    = '0;

    e_mdu #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdu_op(mdu_op),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Architectural effect of one accepted instruction, using plain wide arithmetic.
    function automatic void modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          sp;
        longint unsigned up;
        case (op)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sp = sa * sb;
                modelHi = sp[63:32];
                modelLo = sp[31:0];
            end
            3'd1: begin
                up = longint'(a);
                up = up * longint'(b);
                modelHi = up[63:32];
                modelLo = up[31:0];
            end
            3'd2: begin
                if (b != 32'd0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    sp = sa / sb;
                    modelLo = sp[31:0];
                    sp = sa % sb;
                    modelHi = sp[31:0];
                end
            end
            3'd3: begin
                if (b != 32'd0) begin
                    modelLo = a / b;
                    modelHi = a % b;
                end
            end
            3'd4: modelHi = a;
            3'd5: modelLo = a;
            default: ;
        endcase
    endfunction

    function automatic int latencyOf(input logic [2:0] op);
        if (op <= 3'd1) return MULT_CYCLES;
        if (op <= 3'd3) return DIV_CYCLES;
        return 0;
    endfunction

    // Presents one start pulse; returns at the falling edge just after the sampling edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        mdu_op = 3'($urandom_range(0, 7));
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic countBusy(input int already, output int cyc);
        cyc = already;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        applyStimulus(op, a, b);
        countBusy(0, cyc);
        modelOp(op, a, b);
        checkOutput({tag, "_busy"}, 32'(cyc), 32'(latencyOf(op)));
        checkOutput({tag, "_hi"}, hi, modelHi);
        checkOutput({tag, "_lo"}, lo, modelLo);
    endtask

    initial begin
        int          cyc;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        reset  = 1'b0;
        start  = 1'b0;
        mdu_op = 3'd6;
        rs_val = '0;
        rt_val = '0;
        #12;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        runAndCheck("mult", 3'd0, 32'hFFFFFFFF, 32'd2);
        checkOutput("mult_hi_const", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo_const", lo, 32'hFFFFFFFE);
        runAndCheck("multu", 3'd1, 32'hFFFFFFFF, 32'd2);
        checkOutput("multu_hi_const", hi, 32'h00000001);
        runAndCheck("div", 3'd2, 32'hFFFFFFF9, 32'd2);
        checkOutput("div_lo_const", lo, 32'hFFFFFFFD);
        checkOutput("div_hi_const", hi, 32'hFFFFFFFF);
        runAndCheck("divu", 3'd3, 32'd7, 32'd2);
        runAndCheck("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        checkOutput("div_ovf_lo_const", lo, 32'h80000000);
        runAndCheck("mthi", 3'd4, 32'h1234, 32'd0);
        runAndCheck("divu_zero", 3'd3, 32'd99, 32'd0);
        checkOutput("divu_zero_hi_const", hi, 32'h1234);

        // MTLO pulsed while a multiply is in flight must vanish.
        applyStimulus(3'd0, 32'd3, 32'd4);
        start  = 1'b1;
        mdu_op = 3'd5;
        rs_val = 32'hAAAA;
        @(negedge clk);
        start = 1'b0;
        countBusy(1, cyc);
        modelOp(3'd0, 32'd3, 32'd4);
        checkOutput("ignore_busy", 32'(cyc), 32'(MULT_CYCLES));
        checkOutput("ignore_lo", lo, 32'hC);
        checkOutput("ignore_hi", hi, 32'd0);

        // A start on the same edge busy falls is still refused.
        applyStimulus(3'd1, 32'h00010000, 32'h00030000);
        for (int i = 1; i < MULT_CYCLES; i++) @(negedge clk);
        start  = 1'b1;
        mdu_op = 3'd4;
        rs_val = 32'h5555;
        @(negedge clk);
        start = 1'b0;
        modelOp(3'd1, 32'h00010000, 32'h00030000);
        checkOutput("b2b_busy", {31'd0, busy}, 32'd0);
        checkOutput("b2b_hi", hi, modelHi);
        checkOutput("b2b_lo", lo, modelLo);
        runAndCheck("b2b_reissue", 3'd4, 32'h5555, 32'd0);

        // Asynchronous reset in the middle of a divide.
        runAndCheck("pre_mthi", 3'd4, 32'hDEAD, 32'd0);
        runAndCheck("pre_mtlo", 3'd5, 32'hBEEF, 32'd0);
        applyStimulus(3'd2, 32'd100, 32'd7);
        for (int i = 1; i < 4; i++) @(negedge clk);
        checkOutput("midrst_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_hi", hi, 32'd0);
        checkOutput("midrst_lo", lo, 32'd0);
        modelHi = '0;
        modelLo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (DIV_CYCLES) @(negedge clk);
        checkOutput("postrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("postrst_hi", hi, 32'd0);
        checkOutput("postrst_lo", lo, 32'd0);

        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            runAndCheck($sformatf("rand%0d_op%0d", n, op), op, a, b);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
